// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - b_in, LSB first, one bit per clock.
// Start/busy/done handshake; results held until the next completion.
module serial_sub #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         b_out,
  output logic         ovf
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic [N-1:0]  z;
  logic          br;
  logic          sa;
  logic          sb;
  logic [CW-1:0] cnt;

  logic d;
  logic br_nx;
  logic accept;
  logic last;

  assign d      = x[0] ^ y[0] ^ br;
  assign br_nx  = (~x[0] & y[0]) | (~(x[0] ^ y[0]) & br);
  assign accept = start & ((state == IDLE) | (state == DONE));
  assign last   = (state == RUN) && (cnt == CW'(N - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: start is only honoured in IDLE or DONE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, serial datapath and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x     <= '0;
      y     <= '0;
      z     <= '0;
      br    <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      b_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      x   <= a;
      y   <= b;
      br  <= b_in;
      sa  <= a[N-1];
      sb  <= b[N-1];
      cnt <= '0;
      z   <= '0;
    end else if (state == RUN) begin
      z   <= {d, z[N-1:1]};
      x   <= x >> 1;
      y   <= y >> 1;
      br  <= br_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        D     <= {d, z[N-1:1]};
        b_out <= br_nx;
        ovf   <= (sa ^ sb) & (sa ^ d);
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub: directed cases, exhaustive sweep and
// randomized traffic checked against an arithmetic reference model.
module tb_serial_sub;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] D;
  logic         b_out;
  logic         ovf;

  int n_vec;
  int n_err;

  serial_sub #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .b_out (b_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: {D, b_out, ovf} from plain integer arithmetic
  function automatic logic [5:0] ref_sub(input int ra, input int rb,
                                         input int rbin);
    int diff;
    int sa;
    int sb;
    int sd;
    logic [3:0] rd;
    logic rbo;
    logic rov;
    diff = ra - rb - rbin;
    rd   = 4'(diff & 15);
    rbo  = (diff < 0);
    sa   = (ra >= 8) ? ra - 16 : ra;
    sb   = (rb >= 8) ? rb - 16 : rb;
    sd   = sa - sb - rbin;
    rov  = (sd < -8) || (sd > 7);
    return {rd, rbo, rov};
  endfunction

  // One operation: accept, optional noise during RUN, bounded wait for done
  task automatic run_op(input int ta, input int tb, input int tbin,
                        input bit noise);
    logic [5:0] e;
    int n;
    e = ref_sub(ta, tb, tbin);
    @(negedge clk);
    start = 1'b1;
    a     = 4'(ta);
    b     = 4'(tb);
    b_in  = 1'(tbin);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    b_in  = 1'($urandom);
    check("busy_on_accept", int'(busy), 1);
    n = 0;
    while (!done && n < N + 4) begin
      if (noise) start = 1'($urandom);
      @(posedge clk);
      #1;
      n++;
      if (noise) begin
        a    = 4'($urandom);
        b    = 4'($urandom);
        b_in = 1'($urandom);
      end
    end
    start = 1'b0;
    check("latency", n, N);
    check("D", int'(D), int'(e[5:2]));
    check("b_out", int'(b_out), int'(e[1]));
    check("ovf", int'(ovf), int'(e[0]));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;

    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_D", int'(D), 0);
    check("rst_bout", int'(b_out), 0);
    check("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases
    run_op(9, 3, 0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_D", int'(D), 6);
      check("idle_done", int'(done), 0);
      check("idle_busy", int'(busy), 0);
    end
    run_op(3, 9, 0, 1'b0);
    run_op(8, 1, 0, 1'b0);
    run_op(0, 0, 1, 1'b0);

    // Ignored mid-RUN start, then back-to-back via held start
    @(negedge clk);
    start = 1'b1;
    a     = 4'd5;
    b     = 4'd2;
    b_in  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 4'd15;
    b     = 4'd15;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 4'd12;
    b     = 4'd4;
    @(posedge clk);
    #1;
    check("b2b_done1", int'(done), 1);
    check("b2b_D1", int'(D), 3);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy_nogap", int'(busy), 1);
    check("b2b_done_low", int'(done), 0);
    begin
      int n;
      n = 1;
      while (!done && n < N + 6) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("b2b_gap", n, N + 1);
      check("b2b_D2", int'(D), 8);
    end

    // Reset in the middle of RUN
    @(negedge clk);
    start = 1'b1;
    a     = 4'd9;
    b     = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_D", int'(D), 0);
    check("arst_bout", int'(b_out), 0);
    check("arst_ovf", int'(ovf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (N + 2) begin
      @(posedge clk);
      #1;
      check("arst_no_done", int'(done), 0);
    end
    run_op(9, 3, 0, 1'b0);

    // Exhaustive sweep
    for (int i = 0; i < 512; i++) begin
      run_op(i & 15, (i >> 4) & 15, (i >> 8) & 1, 1'b0);
    end

    // Randomized traffic with noisy inputs and idle gaps
    for (int i = 0; i < 150; i++) begin
      int gap;
      run_op(int'($urandom_range(15)), int'($urandom_range(15)),
             int'($urandom_range(1)), 1'b1);
      @(posedge clk);
      #1;
      check("pulse_one_cycle", int'(done), 0);
      gap = int'($urandom_range(2));
      repeat (gap) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial subtractor computing D = A − B − b_in over N clock cycles, LSB first, with a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the team's bit-serial adder, with the same parallel-in/parallel-out operand style. A start/busy/done handshake replaces free-running operation, so a controller can issue back-to-back operations without tracking a cycle count.

## Interface
- N, 4, operand and result width in bits (N ≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  N  minuend, captured on the accepted start edge
- b  input  N  subtrahend, captured on the accepted start edge
- b_in  input  1  borrow-in, captured on the accepted start edge
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse when D, b_out and ovf are valid
- D  output  N  difference, held until the next completion
- b_out  output  1  borrow-out (1 means unsigned A < B + b_in)
- ovf  output  1  two's-complement signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- Registers:
  - x, y: operand shift registers
  - br: running borrow
  - z: result shift register
  - cnt: bit counter, width $clog2(N+1)
  - sa, sb: captured sign bits
- IDLE or DONE with start=1:
  - x←a, y←b, br←b_in, sa←a[N−1], sb←b[N−1]
  - cnt←0, z←0
  - state←RUN
- DONE with start=0: state←IDLE.
- RUN, every edge:
  - Difference bit: d = x[0]^y[0]^br.
  - Borrow update: br ← (~x[0]&y[0]) | (~(x[0]^y[0])&br).
  - z ← {d, z[N−1:1]}; x and y shift right by one; cnt←cnt+1.
- RUN with cnt==N−1 on the edge:
  - D ← {d, z[N−1:1]}
  - b_out ← borrow computed for that bit
  - ovf ← (sa^sb) & (sa^d)
  - done←1, state←DONE
- done is registered and high only in the cycle in which state==DONE. busy is high exactly when state==RUN.
- start while in RUN is ignored. It is neither queued nor allowed to corrupt operands.
- a, b and b_in are don't-care except on the accepted start edge.
- Arithmetic is modulo 2^N, with b_out the true borrow. Example: 0 − 0 − 1 gives D = all ones, b_out=1.

## Timing
- Reset (rst=0, async): state=IDLE, busy=0, done=0, D=0, b_out=0, ovf=0, and all internal registers 0. This applies immediately and without a clock.
- Reset asserted mid-RUN aborts the operation. No done pulse follows, and D/b_out/ovf read 0.
- Release from reset is synchronous in effect: the first edge with rst=1 may accept start.
- Latency: if start is accepted at edge E, busy is high from E until edge E+N, and done, D, b_out and ovf update at edge E+N.
- done is high for exactly one cycle. D, b_out and ovf hold their values until the next completion or reset.
- Back-to-back: start=1 during the DONE cycle is accepted at that edge, and busy rises with no idle cycle in between. Throughput is one result per N+1 cycles.
- start held high continuously gives a new operation every N+1 cycles, using operands sampled at each accepting edge.

## Test plan
- N=4, reset, then start with a=9, b=3, b_in=0 → busy for 4 cycles; done 4 edges after acceptance with D=6, b_out=0, ovf=0; D stays 6 while idle.
- a=3, b=9, b_in=0 → D=10 (4'b1010), b_out=1, ovf=1 (signed 3 − (−7) = 10 overflows).
- a=8, b=1, b_in=0 → D=7, b_out=0, ovf=1; then a=0, b=0, b_in=1 → D=15, b_out=1, ovf=0.
- Start a=5, b=2, then pulse start with a=15, b=15 during RUN, then hold start high through DONE with a=12, b=4 → first done gives D=3, the mid-RUN start is ignored, the second operation begins with no gap, and the second done gives D=8 exactly 5 cycles after the first.
- Drive rst low 2 cycles into a RUN of a=9, b=3 → outputs are 0 immediately and no done pulse appears; after release, start a=9, b=3 → D=6 at normal latency.
- Exhaustive N=4 sweep of a, b, b_in against a reference model: D == (a−b−b_in) mod 16, b_out == (a < b+b_in), and ovf matches the signed range check for every vector.
